// File: rtl/exception_ctrl_if.sv
// Exception-path signal bundle between the exception sequencer and the core datapath/control.
// master = exception_ctrl, slave = core side that raises events and consumes the controls.
interface exception_ctrl_if;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CAUSE_W = 2;

    logic                exc_opcode;
    logic                exc_overflow;
    logic                exc_div0;
    logic                busy;
    logic                epc_write;
    logic                mem_addr_sel;
    logic                mem_read;
    logic [ADDR_W-1:0]   exc_addr;
    logic                ex_control;
    logic                pc_write;
    logic [CAUSE_W-1:0]  cause;
    logic                exc_done;

    modport master (
        input  exc_opcode, exc_overflow, exc_div0,
        output busy, epc_write, mem_addr_sel, mem_read, exc_addr,
               ex_control, pc_write, cause, exc_done
    );

    modport slave (
        output exc_opcode, exc_overflow, exc_div0,
        input  busy, epc_write, mem_addr_sel, mem_read, exc_addr,
               ex_control, pc_write, cause, exc_done
    );
endinterface

// File: rtl/exception_ctrl.sv
// Exception entry sequencer: latches the cause, saves EPC, fetches the handler address
// from the exception vector and loads it into PC while holding the main control unit.
module exception_ctrl #(
    parameter logic [31:0] VEC_BASE = 32'd253,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic             clk,
    input  logic             reset,
    exception_ctrl_if.master bus
);
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CAUSE_W = 2;
    localparam int unsigned CNT_W   = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SAVE  = 3'd1,
        FETCH = 3'd2,
        WAIT  = 3'd3,
        LOAD  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;

    logic                 busy_q, busy_d;
    logic                 epc_write_q, epc_write_d;
    logic                 mem_addr_sel_q, mem_addr_sel_d;
    logic                 mem_read_q, mem_read_d;
    logic [ADDR_W-1:0]    exc_addr_q, exc_addr_d;
    logic                 load_q, load_d;

    // Next state, counter, cause, and the output values that go with the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;

        case (state_q)
            IDLE: begin
                if (bus.exc_opcode || bus.exc_overflow || bus.exc_div0) begin
                    state_d = SAVE;
                    if (bus.exc_opcode) begin
                        cause_d = CAUSE_W'(2'b01);
                    end else if (bus.exc_overflow) begin
                        cause_d = CAUSE_W'(2'b10);
                    end else begin
                        cause_d = CAUSE_W'(2'b11);
                    end
                end
            end
            SAVE: begin
                state_d = FETCH;
            end
            FETCH: begin
                cnt_d   = CNT_LOAD;
                state_d = (MEM_LAT <= 1) ? LOAD : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs are pure functions of the (next) state and latched cause
        busy_d         = (state_d != IDLE);
        epc_write_d    = (state_d == SAVE);
        mem_read_d     = (state_d == FETCH) || (state_d == WAIT);
        mem_addr_sel_d = (state_d == FETCH) || (state_d == WAIT) || (state_d == LOAD);
        load_d         = (state_d == LOAD);
        exc_addr_d     = (state_d == IDLE) ? VEC_BASE
                                           : VEC_BASE + ADDR_W'(cause_d) - ADDR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cause_q        <= '0;
            busy_q         <= 1'b0;
            epc_write_q    <= 1'b0;
            mem_addr_sel_q <= 1'b0;
            mem_read_q     <= 1'b0;
            exc_addr_q     <= VEC_BASE;
            load_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cause_q        <= cause_d;
            busy_q         <= busy_d;
            epc_write_q    <= epc_write_d;
            mem_addr_sel_q <= mem_addr_sel_d;
            mem_read_q     <= mem_read_d;
            exc_addr_q     <= exc_addr_d;
            load_q         <= load_d;
        end
    end

    // PC mux select, PC load and completion pulse all mark the single LOAD cycle
    assign bus.busy         = busy_q;
    assign bus.epc_write    = epc_write_q;
    assign bus.mem_addr_sel = mem_addr_sel_q;
    assign bus.mem_read     = mem_read_q;
    assign bus.exc_addr     = exc_addr_q;
    assign bus.ex_control   = load_q;
    assign bus.pc_write     = load_q;
    assign bus.exc_done     = load_q;
    assign bus.cause        = cause_q;
endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: two instances (MEM_LAT 1 and 3) checked every cycle against a
// sequence-position model, plus directed scenarios with literal expectations.
module tb_exception_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic eo = 1'b0, ev = 1'b0, ed = 1'b0;

    always #5 clk = ~clk;

    exception_ctrl_if if1 ();
    exception_ctrl_if if3 ();

    assign if1.exc_opcode   = eo;
    assign if1.exc_overflow = ev;
    assign if1.exc_div0     = ed;
    assign if3.exc_opcode   = eo;
    assign if3.exc_overflow = ev;
    assign if3.exc_div0     = ed;

    exception_ctrl #(.VEC_BASE(32'd253), .MEM_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(if1.master));
    exception_ctrl #(.VEC_BASE(32'd253), .MEM_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(if3.master));

    int n_chk = 0;
    int n_err = 0;

    // Model: k = cycles since the accepting edge (0 = idle), sequence length 2+MEM_LAT
    int         k[2];
    logic [1:0] mc[2];
    int         exp_pcw[2];
    int         act_pcw[2];

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [40:0] model_vec(input int kk, input logic [1:0] c, input int l);
        logic [31:0] a;
        a = (kk == 0) ? 32'd253 : 32'd253 + 32'(c) - 32'd1;
        return {kk != 0, kk == 1, kk >= 2, (kk >= 2) && (kk <= 1 + l),
                kk == 2 + l, kk == 2 + l, kk == 2 + l, c, a};
    endfunction

    function automatic logic [40:0] dut_vec(input int d);
        if (d == 0)
            return {if1.busy, if1.epc_write, if1.mem_addr_sel, if1.mem_read, if1.ex_control,
                    if1.pc_write, if1.exc_done, if1.cause, if1.exc_addr};
        return {if3.busy, if3.epc_write, if3.mem_addr_sel, if3.mem_read, if3.ex_control,
                if3.pc_write, if3.exc_done, if3.cause, if3.exc_addr};
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                k[d]  = 0;
                mc[d] = 2'd0;
            end else if (k[d] == 0) begin
                if (eo || ev || ed) begin
                    k[d]  = 1;
                    mc[d] = eo ? 2'd1 : (ev ? 2'd2 : 2'd3);
                end
            end else if (k[d] == 2 + lat(d)) begin
                k[d] = 0;
            end else begin
                k[d] = k[d] + 1;
                if (k[d] == 2 + lat(d)) exp_pcw[d] = exp_pcw[d] + 1;
            end
        end
    endtask

    task automatic compare();
        logic [40:0] act, exp;
        for (int d = 0; d < 2; d++) begin
            act = dut_vec(d);
            exp = model_vec(k[d], mc[d], lat(d));
            n_chk = n_chk + 1;
            if (act !== exp) begin
                n_err = n_err + 1;
                $display("FAIL outputs_lat%0d t=%0t got=%h want=%h (busy,epc,asel,rd,exc,pcw,done,cause,addr)",
                         lat(d), $time, act, exp);
            end
            if (act[35] === 1'b1) act_pcw[d] = act_pcw[d] + 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    initial begin
        int p1, p3, s;
        for (int d = 0; d < 2; d++) begin
            k[d] = 0; mc[d] = 2'd0; exp_pcw[d] = 0; act_pcw[d] = 0;
        end

        // Reset state
        tick();
        tick();
        chk("reset_cause", 32'(if1.cause), 32'd0);
        chk("reset_addr", if3.exc_addr, 32'd253);
        chk("reset_busy", 32'(if3.busy), 32'd0);
        reset = 1'b0;
        tick();

        // Single overflow
        ev = 1'b1;
        tick();
        ev = 1'b0;
        chk("ovf_c1_cause", 32'(if1.cause), 32'd2);
        chk("ovf_c1_epc", 32'(if1.epc_write), 32'd1);
        chk("ovf_c1_busy", 32'(if1.busy), 32'd1);
        tick();
        chk("ovf_c2_addr", if1.exc_addr, 32'd254);
        chk("ovf_c2_rd", 32'(if1.mem_read), 32'd1);
        chk("ovf_c2_exc", 32'(if1.ex_control), 32'd0);
        tick();
        chk("ovf_c3_load", {29'd0, if1.ex_control, if1.pc_write, if1.exc_done}, 32'd7);
        tick();
        chk("ovf_c4_pcw", 32'(if1.pc_write), 32'd0);
        chk("ovf_c4_busy", 32'(if1.busy), 32'd0);
        chk("ovf_c4_sticky", 32'(if1.cause), 32'd2);
        repeat (3) tick();

        // Priority
        eo = 1'b1; ev = 1'b1; ed = 1'b1;
        tick();
        eo = 1'b0; ev = 1'b0; ed = 1'b0;
        tick();
        chk("prio_cause", 32'(if1.cause), 32'd1);
        chk("prio_addr", if1.exc_addr, 32'd253);
        chk("prio_addr_lat3", if3.exc_addr, 32'd253);
        repeat (5) tick();

        // div0 with MEM_LAT=3
        ed = 1'b1;
        tick();
        ed = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (c <= 4) begin
                chk("div0_addr", if3.exc_addr, 32'd255);
                chk("div0_rd", 32'(if3.mem_read), 32'd1);
            end else begin
                chk("div0_pcw_edge5", 32'(if3.pc_write), 32'd1);
            end
        end
        repeat (2) tick();

        // Nested div0 during SAVE and during WAIT
        s = act_pcw[1];
        ev = 1'b1;
        tick();
        ev = 1'b0; ed = 1'b1;
        tick();
        ed = 1'b0;
        tick();
        ed = 1'b1;
        tick();
        ed = 1'b0;
        tick();
        chk("nest_cause_lat3", 32'(if3.cause), 32'd2);
        tick();
        chk("nest_cause_lat1", 32'(if1.cause), 32'd2);
        chk("nest_one_pcw", 32'(act_pcw[1] - s), 32'd1);
        repeat (2) tick();

        // Back-to-back with opcode held
        p1 = 0; p3 = 0;
        eo = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            p1 += int'(if1.pc_write);
            p3 += int'(if3.pc_write);
        end
        eo = 1'b0;
        chk("b2b_pulses_lat1", 32'(p1), 32'd3);
        chk("b2b_pulses_lat3", 32'(p3), 32'd2);
        repeat (8) tick();

        // Asynchronous reset while the MEM_LAT=3 instance is in WAIT
        ed = 1'b1;
        tick();
        ed = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            k[d] = 0; mc[d] = 2'd0;
        end
        chk("rst_busy", 32'(if3.busy), 32'd0);
        chk("rst_cause", 32'(if3.cause), 32'd0);
        chk("rst_rd", 32'(if3.mem_read), 32'd0);
        chk("rst_addr", if3.exc_addr, 32'd253);
        chk("rst_pcw", 32'(if1.pc_write), 32'd0);
        tick();
        reset = 1'b0;
        s = act_pcw[1];
        repeat (6) tick();
        chk("rst_no_pcw", 32'(act_pcw[1] - s), 32'd0);

        // Randomized events
        repeat (600) begin
            eo = ($urandom_range(0, 9) == 0);
            ev = ($urandom_range(0, 7) == 0);
            ed = ($urandom_range(0, 5) == 0);
            tick();
        end
        eo = 1'b0; ev = 1'b0; ed = 1'b0;
        repeat (10) tick();

        chk("pcw_total_lat1", 32'(act_pcw[0]), 32'(exp_pcw[0]));
        chk("pcw_total_lat3", 32'(act_pcw[1]), 32'(exp_pcw[1]));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
